// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned PC_W       = 8;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned OPCODE_MSB = 31;
  localparam int unsigned OPCODE_LSB = 28;
  localparam int unsigned OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(0);

  typedef enum logic [1:0] {
    ST_PRIME = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_RESET    = 2'd0,
    PC_SEL_REDIRECT = 2'd1,
    PC_SEL_INC      = 2'd2,
    PC_SEL_HOLD     = 2'd3
  } pc_sel_e;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic               valid;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } ifid_t;

  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: reset vector, redirect target, sequential increment or hold.
// The increment wraps modulo 2**PC_W with no overflow indication.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
  input  logic [1:0]      sel,
  input  logic [PC_W-1:0] pc,
  input  logic [PC_W-1:0] redirect_pc,
  output logic [PC_W-1:0] next_pc_c
);

  logic [PC_W-1:0] pc_inc;

  assign pc_inc = pc + PC_W'(1);

  // Four-way next-PC mux.
  always_comb begin
    next_pc_c = pc;
    case (pc_sel_e'(sel))
      PC_SEL_RESET:    next_pc_c = RESET_PC;
      PC_SEL_REDIRECT: next_pc_c = redirect_pc;
      PC_SEL_INC:      next_pc_c = pc_inc;
      PC_SEL_HOLD:     next_pc_c = pc;
      default:         next_pc_c = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the instruction memory address and
// captures the returned word into the IF/ID register one cycle later.
// Optional build macro FLUSH_ON_REDIRECT_EN squashes the wrong-path word on a redirect;
// without it the word fetched alongside the redirect is captured as valid.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(0)
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic [PC_W-1:0]    addr,
  input  logic [INSTR_W-1:0] instr,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               halted
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] next_pc_c;
  logic [1:0]      pc_sel_c;
  ifid_t           ifid_q;
  ifid_t           ifid_d;
  logic            halted_q;
  logic            halted_d;

  pc_next_sel #(
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .sel         (pc_sel_c),
    .pc          (pc_q),
    .redirect_pc (redirect_pc),
    .next_pc_c   (next_pc_c)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= ST_PRIME;
    else          state_q <= state_d;
  end

  // Next-state: PRIME lasts one cycle, HALT is left only through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PRIME: state_d = halt ? ST_HALT : ST_RUN;
      ST_RUN:   if (halt) state_d = ST_HALT;
      ST_HALT:  state_d = ST_HALT;
      default:  state_d = ST_PRIME;
    endcase
  end

  // Datapath control: PC select, IF/ID update and halted flag (halt > redirect > stall).
  always_comb begin
    pc_sel_c = PC_SEL_HOLD;
    ifid_d   = ifid_q;
    halted_d = 1'b0;
    case (state_q)
      ST_PRIME: begin
        // PRIME holds the PC so the word at RESET_PC is re-read and captured in RUN.
        if (halt) begin
          halted_d     = 1'b1;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (redirect) begin
          pc_sel_c = PC_SEL_REDIRECT;
        end
      end
      ST_RUN: begin
        if (halt) begin
          halted_d     = 1'b1;
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
        end else if (redirect) begin
          pc_sel_c = PC_SEL_REDIRECT;
`ifdef FLUSH_ON_REDIRECT_EN
          ifid_d.valid = 1'b0;
          ifid_d.instr = NOP_INSTR;
`else
          ifid_d.valid = 1'b1;
          ifid_d.pc    = pc_q;
          ifid_d.instr = instr;
`endif
        end else if (!stall) begin
          pc_sel_c     = PC_SEL_INC;
          ifid_d.valid = 1'b1;
          ifid_d.pc    = pc_q;
          ifid_d.instr = instr;
        end
      end
      ST_HALT: begin
        halted_d     = 1'b1;
        ifid_d.valid = 1'b0;
        ifid_d.instr = NOP_INSTR;
      end
      default: ;
    endcase
    // Keep the mux output meaningful while reset is asserted.
    if (!reset_n) pc_sel_c = PC_SEL_RESET;
  end

  // PC, IF/ID and halted registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pc_q     <= RESET_PC;
      ifid_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= next_pc_c;
      ifid_q   <= ifid_d;
      halted_q <= halted_d;
    end
  end

  assign addr     = pc_q;
  assign if_valid = ifid_q.valid;
  assign if_instr = ifid_q.instr;
  assign if_pc    = ifid_q.pc;
  assign halted   = halted_q;

endmodule
